// File: rtl/ternary_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Controller state encoding is visible on state_o.
package ternary_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH    = 2'd0,
    ST_RUN      = 2'd1,
    ST_MUL_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/ternary_pipeline_ctrl.sv
// Pipeline control: post-reset flush, stalls, redirects,
// multi-cycle multiply wait with timeout, halt/resume.
module ternary_pipeline_ctrl
  import ternary_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MUL_TIMEOUT  = 32,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic             mul_start,
  input  logic             mul_done,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mul_timeout_err
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TW = $clog2(MUL_TIMEOUT);
  localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(MUL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] S_MAX = {CNT_W{1'b1}};

  ctrl_state_t   state, state_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          err_set;
  logic          stall_inc;

  // one-hot RUN requests, highest priority wins
  logic r_busy, r_halt, r_mul, r_br, r_lu;

  assign r_busy = dmem_busy;
  assign r_halt = !dmem_busy && halt_req;
  assign r_mul  = !dmem_busy && !halt_req && mul_start;
  assign r_br   = !dmem_busy && !halt_req && !mul_start
                  && branch_taken;
  assign r_lu   = !dmem_busy && !halt_req && !mul_start
                  && !branch_taken && load_use_hazard;

  assign state_o = state;

  // next state, counter updates and Mealy stage controls
  always_comb begin
    state_nx     = state;
    fcnt_nx      = fcnt;
    tcnt_nx      = tcnt;
    err_set      = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    unique case (state)
      ST_FLUSH: begin
        pc_en        = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        if (fcnt == F_LAST) begin
          fcnt_nx  = '0;
          state_nx = ST_RUN;
        end else begin
          fcnt_nx = fcnt + 1'b1;
        end
      end
      ST_RUN: begin
        unique case (1'b1)
          r_busy: begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end
          r_halt: begin
            pc_en    = 1'b0;
            state_nx = ST_HALTED;
          end
          r_mul: begin
            if (!mul_done) begin
              pc_en        = 1'b0;
              if_id_en     = 1'b0;
              id_ex_en     = 1'b0;
              ex_mem_flush = 1'b1;
              tcnt_nx      = '0;
              state_nx     = ST_MUL_WAIT;
            end
          end
          r_br: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end
          r_lu: begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MUL_WAIT: begin
        if (dmem_busy) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else if (mul_done) begin
          tcnt_nx  = '0;
          state_nx = ST_RUN;
        end else if (tcnt == T_LAST) begin
          err_set  = 1'b1;
          tcnt_nx  = '0;
          state_nx = ST_RUN;
        end else begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          tcnt_nx      = tcnt + 1'b1;
        end
      end
      ST_HALTED: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        if (resume) state_nx = ST_RUN;
      end
      default: ;
    endcase
  end

  assign stall_inc = !pc_en
                     && (state == ST_RUN || state == ST_MUL_WAIT);

  // state, counters and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_FLUSH;
      fcnt            <= '0;
      tcnt            <= '0;
      stall_cycles    <= '0;
      mul_timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      tcnt  <= tcnt_nx;
      if (stall_inc && stall_cycles != S_MAX)
        stall_cycles <= stall_cycles + 1'b1;
      if (err_set) mul_timeout_err <= 1'b1;
    end
  end

endmodule
